// File: rtl/axi_cmd_arbiter_if.sv
// axi_cmd_arbiter_if: requester ports and simple AXI master command bus around the arbiter
interface axi_cmd_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic req0, rw0, done0;
    logic req1, rw1, done1;
    logic [ADDR_WIDTH-1:0] addr0, addr1, m_addr;
    logic [DATA_WIDTH-1:0] wdata0, wdata1, m_wdata, rdata, m_rdata;
    logic err, txn, m_rw, m_rvalid, m_busy;
    logic [1:0] gnt;
    modport slave (
        input req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, m_rdata, m_rvalid, m_busy,
        output done0, done1, rdata, err, gnt, txn, m_rw, m_addr, m_wdata
    );
    modport master (
        output req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, m_rdata, m_rvalid, m_busy,
        input done0, done1, rdata, err, gnt, txn, m_rw, m_addr, m_wdata
    );
endinterface

// File: rtl/axi_cmd_arbiter.sv
// axi_cmd_arbiter: round-robin sharing of one simple AXI-Lite command port between two requesters
module axi_cmd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT = 1024
) (
    input logic clk,
    input logic rst,
    axi_cmd_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP, DRAIN} state_t;
    localparam int CW = $clog2(TIMEOUT);
    state_t state;
    logic last;
    logic pick;
    logic tmo;
    logic [CW-1:0] cnt;
    logic [DATA_WIDTH-1:0] cap;
    always_comb pick = (bus.req0 && bus.req1) ? ~last : bus.req1;
    // cnt lags the cycle count by one, so this lands the error response TIMEOUT cycles after txn
    always_comb tmo = cnt == CW'(TIMEOUT - 2);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last <= 1'b1;
            cnt <= '0;
            cap <= '0;
            bus.gnt <= '0;
            bus.txn <= 1'b0;
            bus.m_rw <= 1'b0;
            bus.m_addr <= '0;
            bus.m_wdata <= '0;
            bus.rdata <= '0;
            bus.err <= 1'b0;
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
        end else begin
            bus.txn <= 1'b0;
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
            case (state)
                IDLE: if (!bus.m_busy && (bus.req0 || bus.req1)) begin
                    bus.gnt <= pick ? 2'b10 : 2'b01;
                    last <= pick;
                    bus.m_rw <= pick ? bus.rw1 : bus.rw0;
                    bus.m_addr <= pick ? bus.addr1 : bus.addr0;
                    bus.m_wdata <= pick ? bus.wdata1 : bus.wdata0;
                    cap <= '0;
                    bus.txn <= 1'b1;
                    state <= ISSUE;
                end
                ISSUE: begin
                    cnt <= '0;
                    state <= WAIT_START;
                end
                WAIT_START, WAIT_DONE: begin
                    cnt <= cnt + 1'b1;
                    if (state == WAIT_DONE && bus.m_rvalid) cap <= bus.m_rdata;
                    if (state == WAIT_DONE && !bus.m_busy) begin
                        bus.rdata <= !bus.m_rw ? '0 : bus.m_rvalid ? bus.m_rdata : cap;
                        bus.err <= 1'b0;
                        bus.done0 <= bus.gnt[0];
                        bus.done1 <= bus.gnt[1];
                        state <= RESP;
                    end else if (tmo) begin
                        bus.rdata <= '0;
                        bus.err <= 1'b1;
                        bus.done0 <= bus.gnt[0];
                        bus.done1 <= bus.gnt[1];
                        state <= RESP;
                    end else if (state == WAIT_START && bus.m_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                RESP: begin
                    bus.gnt <= '0;
                    state <= (bus.err && bus.m_busy) ? DRAIN : IDLE;
                end
                DRAIN: if (!bus.m_busy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// tb_axi_cmd_arbiter: directed checks of arbitration, timeout, drain and reset abort
module tb_axi_cmd_arbiter;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int passed = 0;
  int n_done0 = 0;
  int n_done1 = 0;
  int n_both = 0;
  int m_dly, m_len;
  logic [31:0] m_data;
  int cyc, k, nd0;
  int order [4];
  axi_cmd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  axi_cmd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic do_txn(input int p, input logic rw, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_cyc);
    int c = 0;
    if (p == 1) begin
      bus.req1 = 1'b1; bus.rw1 = rw; bus.addr1 = a; bus.wdata1 = wd;
    end else begin
      bus.req0 = 1'b1; bus.rw0 = rw; bus.addr0 = a; bus.wdata0 = wd;
    end
    while (!(bus.done0 || bus.done1) && c < 100) begin
      tick();
      c++;
    end
    chk("txn_cycles", c, exp_cyc);
    chk("txn_done_port", {bus.done1, bus.done0}, p == 1 ? 2'b10 : 2'b01);
    chk("txn_rdata", bus.rdata, exp_rd);
    chk("txn_err", bus.err, exp_err);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
  endtask
  always @(negedge clk) begin
    if (bus.done0) n_done0++;
    if (bus.done1) n_done1++;
    if (bus.done0 && bus.done1) n_both++;
  end
  // behavioural AXI master: busy m_len cycles starting m_dly cycles after txn, rvalid on the last busy cycle of a read
  initial begin
    bus.m_busy = 1'b0;
    bus.m_rvalid = 1'b0;
    bus.m_rdata = '0;
    forever begin
      tick();
      if (bus.txn && m_dly >= 0) begin
        repeat (m_dly) tick();
        bus.m_busy = 1'b1;
        repeat (m_len - 1) tick();
        bus.m_rvalid = bus.m_rw;
        bus.m_rdata = m_data;
        tick();
        bus.m_busy = 1'b0;
        bus.m_rvalid = 1'b0;
      end
    end
  end
  initial begin
    rst = 1'b1;
    bus.req0 = 1'b0; bus.rw0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.rw1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    m_dly = 1; m_len = 5; m_data = '0;
    repeat (3) tick();
    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_txn", bus.txn, 1'b0);
    chk("rst_done", {bus.done1, bus.done0}, 2'b00);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_m_addr", bus.m_addr, 32'h0);
    // port 0 write, master busy 5 cycles
    rst = 1'b0;
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 32'h4000_0004; bus.wdata0 = 32'hDEAD_BEEF;
    tick();
    chk("w0_txn", bus.txn, 1'b1);
    chk("w0_gnt", bus.gnt, 2'b01);
    chk("w0_m_addr", bus.m_addr, 32'h4000_0004);
    chk("w0_m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
    chk("w0_m_rw", bus.m_rw, 1'b0);
    tick();
    chk("w0_txn_pulse", bus.txn, 1'b0);
    repeat (5) tick();
    chk("w0_busy_fell", bus.m_busy, 1'b0);
    chk("w0_done_early", bus.done0, 1'b0);
    tick();
    chk("w0_done0", bus.done0, 1'b1);
    chk("w0_done1", bus.done1, 1'b0);
    chk("w0_err", bus.err, 1'b0);
    chk("w0_rdata", bus.rdata, 32'h0);
    bus.req0 = 1'b0;
    tick();
    chk("w0_done_pulse", bus.done0, 1'b0);
    chk("w0_gnt_idle", bus.gnt, 2'b00);
    chk("w0_no_done1", n_done1, 0);
    // port 1 read, rvalid on the last busy cycle
    m_len = 3; m_data = 32'h1234_5678;
    bus.req1 = 1'b1; bus.rw1 = 1'b1; bus.addr1 = 32'h10;
    tick();
    chk("r1_gnt", bus.gnt, 2'b10);
    chk("r1_txn", bus.txn, 1'b1);
    chk("r1_m_addr", bus.m_addr, 32'h10);
    chk("r1_m_rw", bus.m_rw, 1'b1);
    repeat (4) tick();
    chk("r1_gnt_hold", bus.gnt, 2'b10);
    chk("r1_done_early", bus.done1, 1'b0);
    tick();
    chk("r1_done1", bus.done1, 1'b1);
    chk("r1_done0", bus.done0, 1'b0);
    chk("r1_rdata", bus.rdata, 32'h1234_5678);
    chk("r1_err", bus.err, 1'b0);
    bus.req1 = 1'b0;
    tick();
    chk("r1_rdata_hold", bus.rdata, 32'h1234_5678);
    // simultaneous requests after reset, both held: 0,1,0,1
    rst = 1'b1;
    tick();
    chk("rst2_rdata", bus.rdata, 32'h0);
    rst = 1'b0;
    m_len = 2;
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 32'h100; bus.wdata0 = 32'h1;
    bus.req1 = 1'b1; bus.rw1 = 1'b0; bus.addr1 = 32'h200; bus.wdata1 = 32'h2;
    tick();
    chk("rr_first_gnt", bus.gnt, 2'b01);
    chk("rr_first_addr", bus.m_addr, 32'h100);
    k = 0; cyc = 0;
    while (k < 4 && cyc < 200) begin
      tick();
      cyc++;
      if (bus.done0 || bus.done1) begin
        order[k] = bus.done1 ? 1 : 0;
        k++;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
    chk("rr_count", k, 4);
    chk("rr_order0", order[0], 0);
    chk("rr_order1", order[1], 1);
    chk("rr_order2", order[2], 0);
    chk("rr_order3", order[3], 1);
    // timeout with a master that never goes busy, framed by normal reads
    m_len = 2; m_data = 32'hA5A5_0001;
    do_txn(1, 1'b1, 32'h30, 32'h0, 32'hA5A5_0001, 1'b0, 5);
    m_dly = -1;
    do_txn(0, 1'b1, 32'h20, 32'h0, 32'h0, 1'b1, 17);
    m_dly = 1; m_data = 32'h0BAD_F00D;
    do_txn(1, 1'b1, 32'h40, 32'h0, 32'h0BAD_F00D, 1'b0, 5);
    // timeout with busy stuck for 40 cycles, port 1 pending
    m_len = 40; m_data = 32'hCAFE_0005;
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 32'h50; bus.wdata0 = 32'h77;
    bus.req1 = 1'b1; bus.rw1 = 1'b1; bus.addr1 = 32'h60;
    cyc = 0;
    while (!bus.done0 && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("st_tmo_cycles", cyc, 17);
    chk("st_err", bus.err, 1'b1);
    chk("st_rdata", bus.rdata, 32'h0);
    chk("st_gnt_resp", bus.gnt, 2'b01);
    bus.req0 = 1'b0;
    m_len = 2;
    tick();
    chk("st_drain_gnt", bus.gnt, 2'b00);
    cyc = 0;
    while (!bus.txn && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("st_drain_cycles", cyc, 26);
    chk("st_next_gnt", bus.gnt, 2'b10);
    chk("st_next_addr", bus.m_addr, 32'h60);
    cyc = 0;
    while (!bus.done1 && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("st_next_cycles", cyc, 4);
    chk("st_next_rdata", bus.rdata, 32'hCAFE_0005);
    chk("st_next_err", bus.err, 1'b0);
    bus.req1 = 1'b0;
    tick();
    // reset during WAIT_DONE with req0 held through it
    m_len = 30;
    bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.addr0 = 32'h70;
    repeat (4) tick();
    chk("ra_gnt", bus.gnt, 2'b01);
    nd0 = n_done0;
    rst = 1'b1;
    tick();
    chk("ra_gnt_rst", bus.gnt, 2'b00);
    chk("ra_m_addr_rst", bus.m_addr, 32'h0);
    chk("ra_m_rw_rst", bus.m_rw, 1'b0);
    chk("ra_rdata_rst", bus.rdata, 32'h0);
    chk("ra_done_rst", {bus.done1, bus.done0}, 2'b00);
    chk("ra_txn_rst", bus.txn, 1'b0);
    rst = 1'b0;
    m_len = 2; m_data = 32'h600D_0006;
    cyc = 0;
    while (!bus.txn && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("ra_retxn_cycles", cyc, 28);
    chk("ra_retxn_gnt", bus.gnt, 2'b01);
    chk("ra_retxn_addr", bus.m_addr, 32'h70);
    cyc = 0;
    while (!bus.done0 && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("ra_done_cycles", cyc, 4);
    chk("ra_rdata", bus.rdata, 32'h600D_0006);
    bus.req0 = 1'b0;
    tick();
    chk("ra_single_done", n_done0, nd0 + 1);
    chk("never_both_done", n_both, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
